lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 31 +++
 rtl/lsu_ctrl.sv | 113 +++++++++++
 tb/tb_lsu_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: controller state encoding, legal lane masks
// and small mask helpers used by both the controller and the lane aligner.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_e;

   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_B1 = 4'b0010;
   localparam logic [3:0] MASK_B2 = 4'b0100;
   localparam logic [3:0] MASK_B3 = 4'b1000;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

   function automatic logic mask_legal(input logic [3:0] m);
      case (m)
         MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H0, MASK_H1, MASK_W: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Index of the lowest enabled byte lane; the lane the right-justified data maps to.
   function automatic logic [1:0] lane_index(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane aligner: places right-justified store data onto its lanes and
// pulls load data off its lanes, truncating and extending it to a right-justified word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [3:0]  st_mask,
   input  logic [31:0] st_data,
   output logic [31:0] st_word,
   input  logic [3:0]  ld_mask,
   input  logic        ld_sx,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [1:0]  st_k;
   logic [1:0]  ld_k;
   logic [31:0] ld_shift;

   always_comb begin
      st_k     = lane_index(st_mask);
      st_word  = st_data << {st_k, 3'b000};
      ld_k     = lane_index(ld_mask);
      ld_shift = ld_word >> {ld_k, 3'b000};
      case (ld_mask)
         MASK_W:           ld_data = ld_shift;
         MASK_H0, MASK_H1: ld_data = {{16{ld_sx & ld_shift[15]}}, ld_shift[15:0]};
         default:          ld_data = {{24{ld_sx & ld_shift[7]}}, ld_shift[7:0]};
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time from execute, issues it to
// data memory with a hold-until-grant request, and returns aligned load data.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] lsu_a,
   input  logic [3:0]  lsu_we,
   input  logic [31:0] lsu_wd,
   input  logic [3:0]  lsu_re,
   input  logic        lsu_sx,
   output logic        lsu_vld,
   output logic [31:0] lsu_rd,
   output logic        lsu_busy,
   output logic        lsu_err,
   output logic        dm_req,
   input  logic        dm_gnt,
   output logic [31:0] dm_adr,
   output logic [3:0]  dm_we,
   output logic [31:0] dm_wd,
   input  logic        dm_rvld,
   input  logic [31:0] dm_rd,
   output logic [1:0]  dbg_state
);

   // Handshake: dm_req/dm_adr/dm_we/dm_wd stay stable from the cycle dm_req rises until
   // the cycle dm_gnt is seen high (transfer on that edge); a load then completes on the
   // first later edge with dm_rvld high. dm_gnt/dm_rvld outside those windows are ignored.
   lsu_state_e state, state_nxt;

   logic        req_st, req_ld, req_ok;
   logic [3:0]  req_mask;
   logic        accept, err_nxt, vld_nxt;
   logic [3:0]  mask_q;
   logic        sx_q;
   logic [31:0] st_word, ld_data;

   lsu_align u_align (
      .st_mask (lsu_we),
      .st_data (lsu_wd),
      .st_word (st_word),
      .ld_mask (mask_q),
      .ld_sx   (sx_q),
      .ld_word (dm_rd),
      .ld_data (ld_data)
   );

   always_comb begin
      req_st    = |lsu_we;
      req_ld    = |lsu_re;
      req_mask  = req_st ? lsu_we : lsu_re;
      req_ok    = !(req_st && req_ld) && mask_legal(req_mask);
      state_nxt = state;
      accept    = 1'b0;
      err_nxt   = 1'b0;
      vld_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (req_st || req_ld) begin
               if (req_ok) begin
                  accept    = 1'b1;
                  state_nxt = REQ;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         REQ: begin
            // A captured store always has a nonzero lane mask, a load has dm_we == 0.
            if (dm_gnt) state_nxt = (dm_we == 4'b0000) ? WAIT : IDLE;
         end
         WAIT: begin
            if (dm_rvld) begin
               vld_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         lsu_vld <= 1'b0;
         lsu_rd  <= 32'h0;
         lsu_err <= 1'b0;
         dm_adr  <= 32'h0;
         dm_we   <= 4'h0;
         dm_wd   <= 32'h0;
         mask_q  <= 4'h0;
         sx_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         lsu_vld <= vld_nxt;
         lsu_err <= err_nxt;
         if (accept) begin
            dm_adr <= lsu_a & 32'hFFFF_FFFC;
            dm_we  <= req_st ? lsu_we : 4'h0;
            dm_wd  <= req_st ? st_word : 32'h0;
            mask_q <= req_mask;
            sx_q   <= lsu_sx;
         end
         if (vld_nxt) lsu_rd <= ld_data;
      end
   end

   assign dm_req    = (state == REQ);
   assign lsu_busy  = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized loads/stores/illegal requests,
// checked against an arithmetic lane model and an expected-load-data queue.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] lsu_a, lsu_wd, lsu_rd, dm_adr, dm_wd, dm_rd;
   logic [3:0]  lsu_we, lsu_re, dm_we;
   logic        lsu_sx, lsu_vld, lsu_busy, lsu_err, dm_req, dm_gnt, dm_rvld;
   logic [1:0]  dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd;
   logic [3:0]  legal_m[7]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   logic [3:0]  illegal_m[8] = '{4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110};

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk(clk), .rstn(rstn), .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd),
      .lsu_re(lsu_re), .lsu_sx(lsu_sx), .lsu_vld(lsu_vld), .lsu_rd(lsu_rd),
      .lsu_busy(lsu_busy), .lsu_err(lsu_err), .dm_req(dm_req), .dm_gnt(dm_gnt),
      .dm_adr(dm_adr), .dm_we(dm_we), .dm_wd(dm_wd), .dm_rvld(dm_rvld), .dm_rd(dm_rd),
      .dbg_state(dbg_state)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [3:0] m, input logic sx);
      int          bits;
      logic [63:0] v, keep;
      bits = $countones(m) * 8;
      v    = {32'h0, w} >> (8 * lowest(m));
      keep = (64'd1 << bits) - 64'd1;
      v    = v & keep;
      if (sx && v[bits-1]) v = v | ~keep;
      return v[31:0];
   endfunction

   task automatic clear_inputs();
      lsu_a = 0; lsu_we = 0; lsu_wd = 0; lsu_re = 0; lsu_sx = 0;
      dm_gnt = 0; dm_rvld = 0; dm_rd = 0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd, input int gd);
      logic [31:0] exp_wd;
      exp_wd = wd << (8 * lowest(we));
      lsu_a = a; lsu_we = we; lsu_re = 0; lsu_wd = wd; lsu_sx = 1'($urandom_range(0, 1));
      @(negedge clk);
      lsu_we = 0; lsu_a = $urandom; lsu_wd = $urandom;
      n_cmp++; if (lsu_vld !== 1'b0) begin n_fail++; $display("FAIL st_no_vld: got %b want 0", lsu_vld); end
      for (int c = 0; c <= gd; c++) begin
         n_cmp++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL st_req c%0d: got %b want 1", c, dm_req); end
         n_cmp++; if (lsu_busy !== 1'b1) begin n_fail++; $display("FAIL st_busy c%0d: got %b want 1", c, lsu_busy); end
         n_cmp++; if (dm_adr !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL st_adr c%0d: got %h want %h", c, dm_adr, a & 32'hFFFF_FFFC); end
         n_cmp++; if (dm_we !== we) begin n_fail++; $display("FAIL st_we c%0d: got %b want %b", c, dm_we, we); end
         n_cmp++; if (dm_wd !== exp_wd) begin n_fail++; $display("FAIL st_wd c%0d: got %h want %h", c, dm_wd, exp_wd); end
         lsu_re  = legal_m[$urandom_range(0, 6)];
         dm_rvld = 1'($urandom_range(0, 1));
         dm_gnt  = (c == gd);
         @(negedge clk);
         dm_gnt = 0; dm_rvld = 0; lsu_re = 0;
      end
      n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL st_req_done: got %b want 0", dm_req); end
      n_cmp++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL st_busy_done: got %b want 0", lsu_busy); end
      n_cmp++; if (lsu_vld !== 1'b0) begin n_fail++; $display("FAIL st_vld_done: got %b want 0", lsu_vld); end
   endtask

   // Ends on the cycle lsu_vld is high so a following request can be back-to-back.
   task automatic do_load(input logic [31:0] a, input logic [3:0] re, input logic sx,
                          input logic [31:0] rd, input int gd, input int rdl);
      logic [31:0] exp_rd;
      lsu_a = a; lsu_re = re; lsu_we = 0; lsu_sx = sx; lsu_wd = $urandom;
      exp_q.push_back(model_load(rd, re, sx));
      @(negedge clk);
      lsu_re = 0; lsu_a = $urandom; lsu_sx = ~sx;
      for (int c = 0; c <= gd; c++) begin
         n_cmp++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL ld_req c%0d: got %b want 1", c, dm_req); end
         n_cmp++; if (dm_adr !== (a & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL ld_adr c%0d: got %h want %h", c, dm_adr, a & 32'hFFFF_FFFC); end
         n_cmp++; if (dm_we !== 4'b0000) begin n_fail++; $display("FAIL ld_we c%0d: got %b want 0000", c, dm_we); end
         lsu_we  = legal_m[$urandom_range(0, 6)];
         dm_rvld = 1'($urandom_range(0, 1));
         dm_gnt  = (c == gd);
         @(negedge clk);
         dm_gnt = 0; dm_rvld = 0; lsu_we = 0;
      end
      for (int d = 0; d <= rdl; d++) begin
         n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL ld_wait_req d%0d: got %b want 0", d, dm_req); end
         n_cmp++; if (lsu_busy !== 1'b1) begin n_fail++; $display("FAIL ld_wait_busy d%0d: got %b want 1", d, lsu_busy); end
         n_cmp++; if (lsu_vld !== 1'b0) begin n_fail++; $display("FAIL ld_wait_vld d%0d: got %b want 0", d, lsu_vld); end
         dm_gnt = 1'($urandom_range(0, 1));
         lsu_we = legal_m[$urandom_range(0, 6)];
         dm_rd  = $urandom;
         if (d == rdl) begin dm_rvld = 1; dm_rd = rd; end
         @(negedge clk);
         dm_rvld = 0; dm_gnt = 0; lsu_we = 0; dm_rd = $urandom;
      end
      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++; if (lsu_vld !== 1'b1) begin n_fail++; $display("FAIL ld_vld: got %b want 1", lsu_vld); end
      n_cmp++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL ld_busy_done: got %b want 0", lsu_busy); end
      n_cmp++; if (lsu_rd !== exp_rd) begin n_fail++; $display("FAIL ld_rd: got %h want %h", lsu_rd, exp_rd); end
      last_rd = exp_rd;
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      n_cmp++; if (lsu_vld !== 1'b0) begin n_fail++; $display("FAIL %s_vld: got %b want 0", tag, lsu_vld); end
      n_cmp++; if (lsu_rd !== last_rd) begin n_fail++; $display("FAIL %s_rd_hold: got %h want %h", tag, lsu_rd, last_rd); end
      n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL %s_req: got %b want 0", tag, dm_req); end
      n_cmp++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", tag, lsu_busy); end
   endtask

   task automatic do_illegal(input logic [3:0] we, input logic [3:0] re);
      lsu_a = $urandom; lsu_we = we; lsu_re = re; lsu_wd = $urandom;
      @(negedge clk);
      lsu_we = 0; lsu_re = 0;
      n_cmp++; if (lsu_err !== 1'b1) begin n_fail++; $display("FAIL ill_err we=%b re=%b: got %b want 1", we, re, lsu_err); end
      n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL ill_req: got %b want 0", dm_req); end
      n_cmp++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL ill_busy: got %b want 0", lsu_busy); end
      @(negedge clk);
      n_cmp++; if (lsu_err !== 1'b0) begin n_fail++; $display("FAIL ill_err_pulse: got %b want 0", lsu_err); end
      n_cmp++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL ill_req2: got %b want 0", dm_req); end
   endtask

   task automatic check_all_zero(input string tag);
      n_cmp++;
      if ({lsu_vld, lsu_rd, lsu_busy, lsu_err, dm_req, dm_adr, dm_we, dm_wd} !== '0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL %s: vld=%b rd=%h busy=%b err=%b req=%b adr=%h we=%b wd=%h state=%0d want all 0",
                  tag, lsu_vld, lsu_rd, lsu_busy, lsu_err, dm_req, dm_adr, dm_we, dm_wd, dbg_state);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rstn = 0;
      lsu_we = 4'b1111; lsu_a = 32'h1234_5678; lsu_wd = 32'hFFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      clear_inputs();
      rstn = 1;
      last_rd = 0;
      @(negedge clk);
      check_all_zero("after_reset");
   endtask

   task automatic test_word_store();
      do_store(32'h100, 4'b1111, 32'hDEADBEEF, 2);
      idle_check("word_store");
   endtask

   task automatic test_half_store();
      do_store(32'h12, 4'b1100, 32'h0000ABCD, 0);
      idle_check("half_store");
   endtask

   task automatic test_byte_load_sx();
      do_load(32'h203, 4'b1000, 1'b1, 32'h80123456, 1, 2);
      idle_check("byte_load");
      do_load(32'h40, 4'b0011, 1'b0, 32'h1234_F00D, 0, 0);
      idle_check("half_load_zx");
   endtask

   task automatic test_illegal();
      do_illegal(4'b0000, 4'b0101);
      do_illegal(4'b0001, 4'b0001);
      do_illegal(4'b1011, 4'b0000);
   endtask

   task automatic test_reset_mid();
      lsu_a = 32'h300; lsu_re = 4'b1111; lsu_sx = 0;
      @(negedge clk);
      lsu_re = 0; dm_gnt = 1;
      @(negedge clk);
      dm_gnt = 0;
      n_cmp++; if (lsu_busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_busy: got %b want 1", lsu_busy); end
      rstn = 0;
      @(negedge clk);
      rstn = 1; dm_rvld = 1; dm_rd = 32'hCAFE_F00D;
      check_all_zero("rst_wait");
      @(negedge clk);
      dm_rvld = 0;
      last_rd = 0;
      check_all_zero("rst_wait_rvld");
      lsu_a = 32'h44; lsu_we = 4'b0001; lsu_wd = 32'h5A;
      @(negedge clk);
      lsu_we = 0;
      n_cmp++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre: got %b want 1", dm_req); end
      rstn = 0;
      @(negedge clk);
      rstn = 1;
      check_all_zero("rst_req");
   endtask

   task automatic test_back_to_back();
      do_load(32'h500, 4'b0100, 1'b1, 32'h00F0_0000, 0, 1);
      do_store(32'h604, 4'b0011, 32'h0000_1357, 1);
      idle_check("b2b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0, 1: do_store($urandom, legal_m[$urandom_range(0, 6)], $urandom,
                           $urandom_range(0, 3));
            2, 3: begin
               do_load($urandom, legal_m[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                       $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
               if ($urandom_range(0, 1) == 1) idle_check("rnd_ld");
            end
            default: if ($urandom_range(0, 1) == 1)
                        do_illegal(4'b0000, illegal_m[$urandom_range(0, 7)]);
                     else
                        do_illegal(legal_m[$urandom_range(0, 6)], legal_m[$urandom_range(0, 6)]);
         endcase
      end
      idle_check("rnd_end");
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_half_store();
      test_byte_load_sx();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
